// File: rtl/spi_i2s_pkg.sv
// Shared types and constants for the SPI_I2S transmit engine.
// Holds the FSM encoding, frame-size codes and the frame alignment helpers.
package spi_i2s_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned FILL_W = 4;

    localparam logic [1:0] SIZE_8  = 2'b00;
    localparam logic [1:0] SIZE_16 = 2'b01;
    localparam logic [1:0] SIZE_24 = 2'b10;
    localparam logic [1:0] SIZE_32 = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StFetch,
        StShift,
        StGap
    } tx_state_e;

    // Frame length in bits: 8 * (size + 1).
    function automatic logic [5:0] frame_bits(input logic [1:0] size);
        logic [2:0] bytes;
        bytes = {1'b0, size} + 3'd1;
        return {bytes, 3'b000};
    endfunction

    // Left-justify the frame so its MSB sits in bit 31.
    function automatic logic [WORD_W-1:0] align_frame(input logic [WORD_W-1:0] data,
                                                      input logic [1:0]        size);
        logic [WORD_W-1:0] res;
        res = data;
        unique case (size)
            SIZE_8:  res = data << 24;
            SIZE_16: res = data << 16;
            SIZE_24: res = data << 8;
            SIZE_32: res = data;
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/spi_i2s_tx_shifter_if.sv
// TX FIFO read port plus SPI pad signals of the transmit engine.
// The master modport is the shifter's view; slave is the FIFO/pad side.
interface spi_i2s_tx_shifter_if;
    import spi_i2s_pkg::*;

    logic [FILL_W-1:0] fifo_fill;
    logic              fifo_rd;
    logic [WORD_W-1:0] fifo_rdata;
    logic              spi_sck;
    logic              spi_sdo;
    logic              spi_cs_n;

    modport master (
        input  fifo_fill,
        input  fifo_rdata,
        output fifo_rd,
        output spi_sck,
        output spi_sdo,
        output spi_cs_n
    );

    modport slave (
        output fifo_fill,
        output fifo_rdata,
        input  fifo_rd,
        input  spi_sck,
        input  spi_sdo,
        input  spi_cs_n
    );

endinterface

// File: rtl/spi_i2s_sck_gen.sv
// Serial clock generator: divides clk by 2*CLK_DIV while enabled.
// Idles with sck low and the divider cleared whenever the FSM is not shifting.
module spi_i2s_sck_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic fall
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            sck_q, sck_d;
    logic            tc;

    assign tc   = en && (div_cnt_q == DivLast);
    assign fall = tc && sck_q;
    assign sck  = sck_q;

    always_comb begin
        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        if (!en) begin
            div_cnt_d = '0;
            sck_d     = 1'b0;
        end else if (tc) begin
            div_cnt_d = '0;
            sck_d     = ~sck_q;
        end else begin
            div_cnt_d = div_cnt_q + DivW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
        end
    end

endmodule

// File: rtl/spi_i2s_tx_shifter.sv
// Transmit engine: pops words from the TX FIFO and shifts them out MSB-first
// on a mode-0 SPI link, with back-to-back bursts while data keeps arriving.
module spi_i2s_tx_shifter
    import spi_i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [1:0]                  size_select,
    spi_i2s_tx_shifter_if.master        bus,
    output logic                        busy,
    output logic                        word_done
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    tx_state_e         state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              cs_n_q, cs_n_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              busy_q, busy_d;
    logic              word_done_q, word_done_d;
    logic              can_start;
    logic              sck_en;
    logic              sck_fall;
    logic [5:0]        nbits;

    assign can_start = enable && (bus.fifo_fill != '0);
    assign sck_en    = (state_q == StShift);
    assign nbits     = frame_bits(size_select);

    spi_i2s_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (sck_en),
        .sck  (bus.spi_sck),
        .fall (sck_fall)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        cs_n_d      = cs_n_q;
        word_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (can_start) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StFetch;
            end
            StFetch: begin
                shift_d   = align_frame(bus.fifo_rdata, size_select);
                bit_cnt_d = 5'(nbits - 6'd1);
                cs_n_d    = 1'b0;
                state_d   = StShift;
            end
            StShift: begin
                if (sck_fall) begin
                    shift_d   = {shift_q[WORD_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 5'd1;
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d   = 5'd0;
                        word_done_d = 1'b1;
                        // Burst keeps cs_n low and goes straight to the next pop.
                        if (can_start) begin
                            state_d = StReq;
                        end else begin
                            cs_n_d    = 1'b1;
                            gap_cnt_d = '0;
                            state_d   = StGap;
                        end
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        fifo_rd_d = (state_d == StReq);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            cs_n_q      <= 1'b1;
            fifo_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            cs_n_q      <= cs_n_d;
            fifo_rd_q   <= fifo_rd_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
        end
    end

    // Zero fill guarantees sdo reads 0 once the last bit has gone.
    assign bus.spi_sdo  = shift_q[WORD_W-1];
    assign bus.spi_cs_n = cs_n_q;
    assign bus.fifo_rd  = fifo_rd_q;
    assign busy         = busy_q;
    assign word_done    = word_done_q;

endmodule
